// File: rtl/cmp_scheduler.sv
// Round-robin scheduler that shares one multi-cycle magnitude comparator
// between two requesters: load, run, sample and report {L,E,G} per request.
module cmp_scheduler #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CMP_CYCLES = 32,
  parameter int unsigned OP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [2:0]       rslt,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_load,
  output logic             cmp_op,
  output logic             cmp_clr,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_G
);

  localparam int unsigned CNT_MAX = (CMP_CYCLES > OP_CYCLES) ? CMP_CYCLES : OP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ptr, ptr_nxt;
  logic               owner, owner_nxt;
  logic               win;
  logic               grant_go;
  logic               run_end;
  logic               smp_end;
  logic               flags_ok;
  logic [2:0]         flags;

  logic               gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic               busy_nxt, load_nxt, op_nxt, clr_nxt, err_nxt;
  logic [2:0]         rslt_nxt;
  logic [WIDTH-1:0]   a_nxt, b_nxt;

  // ptr=1 favours requester 1; a lone requester wins regardless of ptr
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    win       = req1 & (~req0 | ptr);
    grant_go  = (state == S_IDLE) && (req0 || req1);
    run_end   = (state == S_RUN) && (cnt == CNT_W'(CMP_CYCLES - 1));
    smp_end   = (state == S_SAMPLE) && (cnt == CNT_W'(OP_CYCLES - 1));

    case (state)
      S_CLR:  state_nxt = S_IDLE;
      S_IDLE: begin
        if (grant_go) begin
          state_nxt = S_LOAD;
          owner_nxt = win;
          ptr_nxt   = ~win;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
      S_RUN: begin
        if (run_end) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (smp_end) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_CLR;
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    gnt0_nxt  = grant_go & ~win;
    gnt1_nxt  = grant_go & win;
    load_nxt  = grant_go;
    op_nxt    = (state_nxt == S_SAMPLE);
    done0_nxt = (state_nxt == S_DONE) & ~owner;
    done1_nxt = (state_nxt == S_DONE) & owner;
    busy_nxt  = (state_nxt != S_IDLE);
    clr_nxt   = (state_nxt == S_CLR) || (state_nxt == S_DONE);

    flags = {cmp_L, cmp_E, cmp_G};
    case (flags)
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase

    rslt_nxt = rslt;
    err_nxt  = err;
    if (smp_end) begin
      rslt_nxt = flags_ok ? flags : 3'b000;
      err_nxt  = ~flags_ok;
    end

    a_nxt = cmp_a;
    b_nxt = cmp_b;
    if (grant_go) begin
      a_nxt = win ? a1 : a0;
      b_nxt = win ? b1 : b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_CLR;
      cnt   <= '0;
      ptr   <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Clear is the only output held high while in reset
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rslt     <= 3'b000;
      err      <= 1'b0;
      busy     <= 1'b0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      cmp_load <= 1'b0;
      cmp_op   <= 1'b0;
      cmp_clr  <= 1'b1;
    end else begin
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      rslt     <= rslt_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      cmp_a    <= a_nxt;
      cmp_b    <= b_nxt;
      cmp_load <= load_nxt;
      cmp_op   <= op_nxt;
      cmp_clr  <= clr_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_scheduler.sv
// Self-checking bench for cmp_scheduler: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-age model.
module tb_cmp_scheduler;

  localparam int unsigned W = 32;
  localparam int C = 32;
  localparam int O = 2;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, err, busy;
  logic [2:0]   rslt;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_load, cmp_op, cmp_clr;
  logic         cmp_L, cmp_E, cmp_G;

  // Comparator stand-in; fen overrides the flags to model a faulty comparator
  logic         fen = 1'b0;
  logic [2:0]   fflags = 3'b000;
  assign cmp_L = fen ? fflags[2] : (cmp_a < cmp_b);
  assign cmp_E = fen ? fflags[1] : (cmp_a == cmp_b);
  assign cmp_G = fen ? fflags[0] : (cmp_a > cmp_b);

  always #5 clk = ~clk;

  cmp_scheduler #(.WIDTH(W), .CMP_CYCLES(C), .OP_CYCLES(O)) dut (
    .clk(clk), .res(res), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rslt(rslt), .err(err), .busy(busy),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_load(cmp_load), .cmp_op(cmp_op), .cmp_clr(cmp_clr),
    .cmp_L(cmp_L), .cmp_E(cmp_E), .cmp_G(cmp_G)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is tracked by its age in cycles since the grant
  bit           m_clr = 1'b1;
  int           m_age = -1;
  bit           m_own = 1'b0;
  bit           m_ptr = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_rslt = 3'b000;
  bit           m_err = 1'b0;

  function automatic bit pick(input logic r0, input logic r1, input bit p);
    return (r0 && r1) ? p : r1;
  endfunction

  function automatic logic [3:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic fe, input logic [2:0] ff);
    logic [2:0] f;
    f = fe ? ff : {a < b, a == b, a > b};
    return ($countones(f) == 1) ? {f, 1'b0} : 4'b0001;
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      m_clr  <= 1'b1;
      m_age  <= -1;
      m_own  <= 1'b0;
      m_ptr  <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
      m_rslt <= 3'b000;
      m_err  <= 1'b0;
    end else if (m_clr) begin
      m_clr <= 1'b0;
    end else if (m_age < 0) begin
      if (req0 || req1) begin
        m_own <= pick(req0, req1, m_ptr);
        m_ptr <= !pick(req0, req1, m_ptr);
        m_a   <= pick(req0, req1, m_ptr) ? a1 : a0;
        m_b   <= pick(req0, req1, m_ptr) ? b1 : b0;
        m_age <= 0;
      end
    end else begin
      m_age <= (m_age == C + O + 1) ? -1 : m_age + 1;
      if (m_age == C + O) {m_rslt, m_err} <= model_result(m_a, m_b, fen, fflags);
    end
  end

  // {gnt0,gnt1,done0,done1,rslt,err,busy,cmp_load,cmp_op,cmp_clr}
  logic [11:0] act_ctl;
  assign act_ctl = {gnt0, gnt1, done0, done1, rslt, err, busy, cmp_load, cmp_op, cmp_clr};

  function automatic logic [11:0] model_ctl();
    logic last;
    last = (m_age == C + O + 1);
    return {m_age == 0 && !m_own, m_age == 0 && m_own, last && !m_own, last && m_own,
            m_rslt, m_err, m_age >= 0, m_age == 0, m_age > C && m_age <= C + O, m_clr || last};
  endfunction

  // busy is not defined for the single clear cycle that follows reset release
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("cycle_ctl", 64'(act_ctl & ((m_clr && res) ? 12'hFF7 : 12'hFFF)),
            64'(model_ctl() & ((m_clr && res) ? 12'hFF7 : 12'hFFF)));
      check("cycle_operands", 64'({cmp_a, cmp_b}), 64'({m_a, m_b}));
    end
  end

  typedef struct {
    logic r0; logic r1;
    logic [W-1:0] a0; logic [W-1:0] b0; logic [W-1:0] a1; logic [W-1:0] b1;
    logic fe; logic [2:0] ff;
    logic who; logic [2:0] rs; logic er;
  } vec_t;
  vec_t vecs [9];

  task automatic wait_gnt(input int max, output bit found, output bit who, output int at);
    found = 1'b0; who = 1'b0; at = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin found = 1'b1; who = gnt1; at = cyc; break; end
    end
  endtask

  task automatic wait_done(input int max, output bit found, output bit who, output int at);
    found = 1'b0; who = 1'b0; at = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done0 || done1) begin found = 1'b1; who = done1; at = cyc; break; end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 res = 1'b1;
  endtask

  task automatic run_vec(input int i);
    bit gf, gw, df, dw;
    int gat, dat;
    @(negedge clk);
    req0 = vecs[i].r0; req1 = vecs[i].r1;
    a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
    fen = vecs[i].fe; fflags = vecs[i].ff;
    wait_gnt(6, gf, gw, gat);
    check($sformatf("v%0d_gnt_seen", i), 64'(gf), 64'(1));
    if (gf) check($sformatf("v%0d_gnt_who", i), 64'(gw), 64'(vecs[i].who));
    req0 = 1'b0; req1 = 1'b0;
    wait_done(60, df, dw, dat);
    check($sformatf("v%0d_done_seen", i), 64'(df), 64'(1));
    if (df && gf) begin
      check($sformatf("v%0d_done_who", i), 64'(dw), 64'(vecs[i].who));
      check($sformatf("v%0d_latency", i), 64'(dat - gat), 64'(C + O + 1));
      check($sformatf("v%0d_result", i), 64'({rslt, err}), 64'({vecs[i].rs, vecs[i].er}));
    end
    fen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit gf, gw, df, dw;
    int gat, dat, prev, cnt_g, cnt_d;

    vecs[0] = '{1'b1, 1'b0, 32'h44464444, 32'h44444444, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h44444444, 32'h44444444, 1'b0, 3'b000, 1'b1, 3'b010, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h1, 32'h2, 32'h5, 32'h3, 1'b0, 3'b000, 1'b0, 3'b100, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h1, 32'h2, 32'h5, 32'h3, 1'b0, 3'b000, 1'b1, 3'b001, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h9, 32'h9, 32'h0, 32'h0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h3, 32'h4, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h3, 32'h4, 1'b1, 3'b111, 1'b1, 3'b000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 3'b000, 1'b1, 3'b100, 1'b0};

    // Reset values, then the one-cycle clear
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_ctl", 64'(act_ctl), 64'(12'h001));
    check("reset_operands", 64'({cmp_a, cmp_b}), 64'(0));
    release_reset();
    @(negedge clk);
    check("clr_cycle", 64'(cmp_clr), 64'(1));
    @(negedge clk);
    check("idle_after_clr", 64'({cmp_clr, busy}), 64'(0));

    for (int i = 0; i < 9; i++) run_vec(i);

    // Round-robin with both requests held
    @(negedge clk) res = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; a0 = 32'd10; b0 = 32'd20; a1 = 32'd30; b1 = 32'd30;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(45, gf, gw, gat);
      check("rr_gnt_seen", 64'(gf), 64'(1));
      check("rr_gnt_who", 64'(gw), 64'(g % 2));
      if (g > 0) check("rr_spacing", 64'(gat - prev), 64'(C + O + 3));
      prev = gat;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_done(60, df, dw, dat);
    check("rr_last_done", 64'({df, dw}), 64'(2'b11));

    // Reset in the middle of RUN aborts the compare
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
    wait_gnt(6, gf, gw, gat);
    req0 = 1'b0;
    repeat (10) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("midrun_reset_ctl", 64'(act_ctl), 64'(12'h001));
    check("midrun_reset_operands", 64'({cmp_a, cmp_b}), 64'(0));
    repeat (2) @(negedge clk);
    release_reset();
    wait_done(50, df, dw, dat);
    check("midrun_no_done", 64'(df), 64'(0));
    run_vec(1);

    // A one-cycle req1 pulse while busy must be ignored
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd100; b0 = 32'd50;
    wait_gnt(6, gf, gw, gat);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    cnt_g = 0; cnt_d = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gnt1) cnt_g++;
      if (done0) cnt_d++;
    end
    check("busy_no_gnt1", 64'(cnt_g), 64'(0));
    check("busy_single_done0", 64'(cnt_d), 64'(1));

    // Randomized traffic, comparator faults and occasional resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        res = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        release_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) req0 = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) req1 = 1'($urandom_range(0, 1));
        a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
        a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
        fen = ($urandom_range(0, 5) == 0);
        fflags = 3'($urandom_range(0, 7));
      end
    end
    req0 = 1'b0; req1 = 1'b0; fen = 1'b0;
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
